mult_rr_arbiter: RTL and testbench
==================================

# mult_rr_arbiter

Round-robin scheduler that shares one combinational signed `Array_multiplier` instance among NREQ requesters. Each requester has a valid/ready operand port. Products return on a single response channel, tagged with the requester index. The block wraps the multiplier in a two-stage pipeline (operand register, then product register) so the array's long combinational path sits between two flops. It sits between the compute clients and the multiplier datapath.

## Interface
- `WIDTH`, 32, operand width in bits; signed two's complement.
- `NREQ`, 4, number of requesters; must be ≥ 2.
- `IDW`, $clog2(NREQ), width of the requester tag.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i high means requester i presents operands.
- `req_ready` output NREQ: one-hot or zero; bit i high means requester i is granted this cycle.
- `req_a` input NREQ*WIDTH: operand A of requester i in bits [i*WIDTH +: WIDTH].
- `req_b` input NREQ*WIDTH: operand B of requester i, same packing.
- `rsp_valid` output 1: response holds a valid product.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_product` output 2*WIDTH: signed A*B, exact.
- `rsp_id` output IDW: index of the requester that produced the result.
- `busy` output 1: high when op_valid or rsp_valid is high.

## Operation
- **Stage S1 (operand register):** holds op_a, op_b, op_id and op_valid. Output feeds the `Array_multiplier #(WIDTH)` instance.
- **Stage S2 (response register):** holds rsp_product, rsp_id and rsp_valid.
- **Advance conditions:**
  - adv2 = !rsp_valid || rsp_ready. S2 loads the S1 contents; rsp_valid takes the value of op_valid.
  - adv1 = !op_valid || adv2. S1 may accept a new request.
- **Arbitration:**
  - Applies only when adv1 is high.
  - Scan req_valid starting at index ptr and moving upward modulo NREQ.
  - The first asserted index g is granted: req_ready[g]=1, all other bits 0.
  - If adv1 is low or no request is valid, req_ready is all zeros.
  - req_ready is combinational from req_valid, ptr and the stage state.
- **On a grant:**
  - S1 loads req_a/req_b slice g, op_id=g, op_valid=1.
  - ptr becomes (g+1) mod NREQ.
  - A granted requester is not regranted until every other valid requester has been served.
- **With adv1 high and no grant:** op_valid=0 and ptr is unchanged.
- **Requester rules:** once req_valid[i] is raised, it and the operands stay stable until req_ready[i]. Requesters never use req_ready to form req_valid.
- **Arithmetic:** full signed multiply, no truncation or saturation.
  - (2^(W-1)-1)*(2^(W-1)-1) is exact.
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- **Stall:** while rsp_valid && !rsp_ready, rsp_product and rsp_id hold. A full S1 holds too; no data is dropped or duplicated.
- **Reset:**
  - ptr=0, op_valid=0, op_a=op_b=0, op_id=0.
  - rsp_valid=0, rsp_product=0, rsp_id=0, busy=0.
  - req_ready=0 during the reset cycle.
  - Reset asserted mid-operation discards in-flight work; outputs return to these values after the edge.

## Timing
- **Latency:** a handshake at rising edge E gives rsp_valid=1 after edge E+1, with the product of those operands. That is 2 cycles from acceptance, when not stalled.
- **Throughput:** one accepted request per cycle with rsp_ready held high.
- **Backpressure:**
  - With rsp_ready low and both stages full, req_ready=0 in the next cycle.
  - When rsp_ready rises, S2 drains at that edge, S1 moves to S2, and a new grant happens in the same cycle.
- **Simultaneous events:**
  - A grant and an S1→S2 move at the same edge are legal and required.
  - A request arriving in the same cycle that ptr points past it waits for the wrap.
- **busy:** registered; mirrors op_valid || rsp_valid of the current state.

## Test plan
- **Reset:** hold rst for 2 cycles with all req_valid high → req_ready=0, rsp_valid=0, rsp_product=0, busy=0. First grant goes to index 0 on the cycle after rst falls.
- **Single request:** req 2 with A=5, B=-3, rsp_ready=1 → accepted at edge E. After E+1, rsp_valid=1, rsp_product=-15, rsp_id=2.
- **Fairness:** all four valid, continuously refilled → grants in order 0,1,2,3,0,1. Responses arrive back-to-back with ids in that order. Operand pairs (2147483647,-2147483648) → -4611686016279904256 and (-2147483648,-2147483648) → 4611686018427387904.
- **Backpressure:** drop rsp_ready for 5 cycles during a stream. rsp_product/rsp_id are stable throughout, req_ready=0 once both stages are full, and no response is lost or duplicated. Checked with a scoreboard against A*B per id.
- **Reset mid-operation:** rst pulsed while both stages are valid → next cycle rsp_valid=0, busy=0, ptr=0. No stale response appears afterwards.
- **Random:** 200 requests with $random operands, valid patterns and rsp_ready patterns → every product equals the signed A*B of the same requester, in per-requester order.

Source files
------------

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one signed array multiplier among NREQ requesters,
// with an operand register in front of the multiplier and a product register after it.

module Array_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;

    // Sign-extend both operands so the 2W-bit product is exact for every signed pair.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign p     = a_ext * b_ext;
endmodule

module mult_rr_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);
    logic [IDW-1:0]     ptr;
    logic               op_valid;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDW-1:0]     op_id;
    logic [2*WIDTH-1:0] mult_p;

    logic               adv1;
    logic               adv2;
    logic               grant_hit;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     scan_idx;
    logic [IDW-1:0]     ptr_next;
    logic               op_valid_next;
    logic               rsp_valid_next;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !op_valid || adv2;

    // First valid requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        req_ready = '0;
        if (adv1 && !rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                scan_idx = IDW'((32'(ptr) + k) % NREQ);
                if (!grant_hit && req_valid[scan_idx]) begin
                    grant_hit = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_hit) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    assign op_valid_next  = adv1 ? grant_hit : op_valid;
    assign rsp_valid_next = adv2 ? op_valid  : rsp_valid;

    Array_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a (op_a),
        .b (op_b),
        .p (mult_p)
    );

    // Both pipeline stages; S2 may empty into the consumer while S1 refills at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
            busy        <= 1'b0;
        end else begin
            if (adv2) begin
                rsp_valid   <= op_valid;
                rsp_product <= mult_p;
                rsp_id      <= op_id;
            end
            if (adv1) begin
                op_valid <= grant_hit;
                if (grant_hit) begin
                    op_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                    op_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                    op_id <= grant_idx;
                    ptr   <= ptr_next;
                end
            end
            busy <= op_valid_next || rsp_valid_next;
        end
    end
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed and randomized bench for mult_rr_arbiter: per-requester scoreboard of
// signed products, grant-order log, stall, reset and boundary-operand checks.

module tb_mult_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_product;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    always #5 clk = ~clk;

    mult_rr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t         src_q [NREQ][$];
    logic [63:0] exp_q [NREQ][$];
    logic        act   [NREQ];
    bit          rand_mode;
    int          grant_log[$];
    int          rsp_id_log[$];
    logic [63:0] rsp_p_log[$];
    int          n_checks;
    int          n_fail;
    int          n_pushed;
    int          n_rsp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < NREQ; i++) s += src_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    task automatic push(input int id, input logic [31:0] a, input logic [31:0] b);
        src_q[id].push_back('{a: a, b: b});
        n_pushed++;
    endtask

    // Present each requester's head operation; once raised, valid holds until accepted.
    task automatic drive();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!act[i] && src_q[i].size() != 0 && (!rand_mode || $urandom_range(0, 1) == 1))
                act[i] = 1'b1;
            if (act[i]) begin
                req_valid[i]          = 1'b1;
                req_a[i*WIDTH +: WIDTH] = src_q[i][0].a;
                req_b[i*WIDTH +: WIDTH] = src_q[i][0].b;
            end
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    // Record handshakes and responses of this cycle, then advance one clock.
    task automatic tick();
        int id;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                grant_log.push_back(i);
                exp_q[i].push_back(model_mul(src_q[i][0].a, src_q[i][0].b));
                void'(src_q[i].pop_front());
                act[i] = 1'b0;
            end
        end
        if (rsp_valid && rsp_ready) begin
            id = int'(rsp_id);
            rsp_p_log.push_back(rsp_product);
            rsp_id_log.push_back(id);
            n_rsp++;
            check_eq("rsp_expected", 64'(exp_q[id].size() != 0), 64'd1);
            if (exp_q[id].size() != 0) begin
                check_eq($sformatf("rsp_product_id%0d", id), rsp_product, exp_q[id][0]);
                void'(exp_q[id].pop_front());
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int bound, output int nc);
        nc = 0;
        while (pending() != 0 && nc < bound) begin
            tick();
            nc++;
        end
        check_eq("drain_pending", 64'(pending()), 64'd0);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_id_log.delete();
        rsp_p_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nc;
        int          stale;
        logic [63:0] held_p;
        logic [63:0] held_id;

        n_checks  = 0;
        n_fail    = 0;
        n_pushed  = 0;
        n_rsp     = 0;
        rand_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
        rst       = 1'b1;
        rsp_ready = 1'b1;

        // Reset held two cycles with every requester valid.
        for (int i = 0; i < NREQ; i++) push(i, 32'(10 + i), 32'd3);
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("rst_req_ready", 64'(req_ready), 64'd0);
            check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("rst_rsp_product", rsp_product, 64'd0);
            check_eq("rst_busy", 64'(busy), 64'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("first_grant", 64'(req_ready), 64'b0001);
        drain(50, nc);
        check_eq("rst_grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4)
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("rst_grant%0d", k), 64'(grant_log[k]), 64'(k));
        check_eq("rst_rsp_count", 64'(n_rsp), 64'd4);

        // Single request from requester 2.
        clear_logs();
        push(2, 32'd5, 32'(-3));
        drive();
        check_eq("single_ready", 64'(req_ready), 64'b0100);
        tick();
        check_eq("single_lat_valid", 64'(rsp_valid), 64'd0);
        check_eq("single_busy", 64'(busy), 64'd1);
        tick();
        check_eq("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("single_product", rsp_product, 64'hFFFF_FFFF_FFFF_FFF1);
        check_eq("single_id", 64'(rsp_id), 64'd2);
        drain(20, nc);

        // Bring ptr back to 0, then a full round-robin stream.
        push(3, 32'd1, 32'd1);
        drive();
        drain(20, nc);
        clear_logs();
        push(0, 32'h7FFF_FFFF, 32'h8000_0000);
        push(1, 32'h8000_0000, 32'h8000_0000);
        push(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        push(3, 32'(-5), 32'd6);
        push(0, 32'd7, 32'd8);
        push(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(2, 32'd0, 32'd123);
        push(3, 32'd100, 32'(-100));
        drive();
        drain(100, nc);
        check_eq("stream_cycles", 64'(nc), 64'd10);
        check_eq("stream_grants", 64'(grant_log.size()), 64'd8);
        check_eq("stream_rsps", 64'(rsp_id_log.size()), 64'd8);
        if (grant_log.size() == 8 && rsp_id_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check_eq($sformatf("stream_grant%0d", k), 64'(grant_log[k]), 64'(k % 4));
                check_eq($sformatf("stream_rsp_id%0d", k), 64'(rsp_id_log[k]), 64'(k % 4));
            end
            check_eq("max_times_min", rsp_p_log[0], 64'hC000_0000_8000_0000);
            check_eq("min_times_min", rsp_p_log[1], 64'h4000_0000_0000_0000);
            check_eq("max_times_max", rsp_p_log[2], 64'h3FFF_FFFF_0000_0001);
        end

        // Backpressure: five stalled cycles with both stages full.
        n_pushed = 0;
        n_rsp    = 0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < NREQ; i++) push(i, 32'(100 * i + j), 32'(-(j + 1)));
        drive();
        tick();
        tick();
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("bp_rsp_id", 64'(rsp_id), 64'd0);
        held_p  = rsp_product;
        held_id = 64'(rsp_id);
        for (int s = 0; s < 5; s++) begin
            check_eq($sformatf("bp_ready%0d", s), 64'(req_ready), 64'd0);
            check_eq($sformatf("bp_hold_p%0d", s), rsp_product, held_p);
            check_eq($sformatf("bp_hold_id%0d", s), 64'(rsp_id), held_id);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_grant", 64'(req_ready), 64'b0100);
        drain(100, nc);
        check_eq("bp_rsp_count", 64'(n_rsp), 64'(n_pushed));

        // Reset pulsed while both stages hold valid work.
        for (int i = 0; i < 2; i++) begin
            push(0, 32'(i + 1), 32'd9);
            push(1, 32'(i + 2), 32'd11);
        end
        drive();
        tick();
        tick();
        check_eq("mid_pre_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("mid_pre_busy", 64'(busy), 64'd1);
        rst       = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            act[i] = 1'b0;
        end
        drive();
        check_eq("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        n_pushed = 0;
        n_rsp    = 0;
        check_eq("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_busy", 64'(busy), 64'd0);
        check_eq("mid_rsp_product", rsp_product, 64'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        push(3, 32'd4, 32'd4);
        push(0, 32'd6, 32'd6);
        drive();
        check_eq("mid_ptr0_grant", 64'(req_ready), 64'b0001);
        drain(50, nc);
        check_eq("mid_rsp_count", 64'(n_rsp), 64'd2);
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) stale++;
            tick();
        end
        check_eq("mid_no_stale", 64'(stale), 64'd0);

        // Random operands, valid patterns and consumer backpressure.
        rand_mode = 1'b1;
        n_pushed  = 0;
        n_rsp     = 0;
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 0) push(n % NREQ, 32'h8000_0000, $urandom);
            else             push($urandom_range(0, NREQ - 1), $urandom, $urandom);
        end
        drive();
        drain(5000, nc);
        check_eq("rand_rsp_count", 64'(n_rsp), 64'd200);
        rand_mode = 1'b0;
        rsp_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
